srl_iter: RTL and testbench



---
 rtl/srl_iter.sv | 104 ++++++++++
 tb/tb_srl_iter.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/srl_iter.sv
// rtl/srl_iter.sv - multi-cycle right shifter, one bit per clock; SRL_ARITH_EN adds sign-fill via port arith
module srl_iter #(
  parameter int WIDTH = 24,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SRL_ARITH_EN
  input  logic             arith,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] shift_amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   amt;
  logic               in_range;
  logic               accept;
  logic               fill;

  // Effective amount wraps at WIDTH bits; zero and oversized amounts skip shifting
  assign amt      = B + shift_amount;
  assign in_range = (amt != '0) && (amt <= WIDTH'(WIDTH - 1));
  assign accept   = (state == ST_IDLE) && start;

`ifdef SRL_ARITH_EN
  // Fill bit is frozen at acceptance so A may change while the shift runs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill <= 1'b0;
    end else if (accept) begin
      fill <= arith & A[WIDTH-1];
    end
  end
`else
  assign fill = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = in_range ? ST_SHIFT : ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (count == CNT_W'(1)) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath: load on acceptance, shift one position per SHIFT cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      count  <= '0;
    end else if (accept) begin
      result <= A;
      count  <= in_range ? amt[CNT_W-1:0] : '0;
    end else if (state == ST_SHIFT) begin
      result <= {fill, result[WIDTH-1:1]};
      count  <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_srl_iter.sv
// tb/tb_srl_iter.sv - scoreboard bench for srl_iter
module tb_srl_iter;

  logic        clk;
  logic        reset;
  logic        start;
  logic        arith_v;
  logic [23:0] A;
  logic [23:0] B;
  logic [23:0] shift_amount;
  logic        busy;
  logic        done;
  logic [23:0] result;

  int checks;
  int failures;

  logic [23:0] exp_res_q[$];
  int          exp_lat_q[$];

  srl_iter dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
`ifdef SRL_ARITH_EN
    .arith        (arith_v),
`endif
    .A            (A),
    .B            (B),
    .shift_amount (shift_amount),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: pushes expected result and latency for one request
  task automatic push(input logic [23:0] a, input logic [23:0] b, input logic [23:0] sa, input logic ar);
    logic [24:0] sum;
    logic [23:0] amt;
    logic [23:0] r;
    logic        sfill;
    sum = {1'b0, b} + {1'b0, sa};
    amt = sum[23:0];
`ifdef SRL_ARITH_EN
    sfill = ar & a[23];
`else
    sfill = 1'b0;
`endif
    if (amt == 0 || amt > 23) begin
      exp_res_q.push_back(a);
      exp_lat_q.push_back(0);
    end else begin
      r = a;
      for (int k = 0; k < int'(amt); k++) r = {sfill, r[23:1]};
      exp_res_q.push_back(r);
      exp_lat_q.push_back(int'(amt));
    end
  endtask

  // Call right after the acceptance edge; optionally injects a second start while busy
  task automatic wait_done(input int inj_at);
    int          lat;
    bit          got;
    logic [23:0] er;
    int          el;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == inj_at) begin
        A = 24'h123456; B = 24'd1; shift_amount = 24'd0; arith_v = 1'b0; start = 1'b1;
        push(24'h123456, 24'd1, 24'd0, 1'b0);
      end
      if (done) begin
        got = 1'b1;
        break;
      end
      check("busy_during_op", {31'd0, busy}, 32'd1);
      lat++;
    end
    check("done_seen", {31'd0, got}, 32'd1);
    if (got && exp_res_q.size() > 0) begin
      er = exp_res_q.pop_front();
      el = exp_lat_q.pop_front();
      check("result", {8'd0, result}, {8'd0, er});
      check("latency", lat, el);
    end
  endtask

  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic [23:0] sa, input logic ar);
    logic [23:0] held;
    @(negedge clk);
    A = a; B = b; shift_amount = sa; arith_v = ar; start = 1'b1;
    push(a, b, sa, ar);
    @(posedge clk);
    wait_done(-1);
    held = result;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
    A = ~A;
    @(negedge clk);
    check("result_held", {8'd0, result}, {8'd0, held});
  endtask

  initial begin
    int cnt;
    checks = 0; failures = 0;
    reset = 1'b1; start = 1'b0; arith_v = 1'b0;
    A = 24'hABCDEF; B = 24'd3; shift_amount = 24'd0;
    #12;
    check("reset_result", {8'd0, result}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(24'h800000, 24'd3, 24'd1, 1'b0);
    do_op(24'h123456, 24'd0, 24'd0, 1'b0);
    do_op(24'h800000, 24'd23, 24'd0, 1'b0);
    do_op(24'h5A5A5A, 24'd20, 24'd4, 1'b0);
    do_op(24'h000006, 24'hFFFFFF, 24'h000002, 1'b0);

    // start while busy is ignored; held start is taken the cycle after done
    @(negedge clk);
    A = 24'h00F000; B = 24'd4; shift_amount = 24'd0; arith_v = 1'b0; start = 1'b1;
    push(24'h00F000, 24'd4, 24'd0, 1'b0);
    @(posedge clk);
    wait_done(1);
    @(negedge clk);
    check("held_start_idle", {31'd0, busy}, 32'd0);
    @(posedge clk);
    wait_done(-1);

`ifdef SRL_ARITH_EN
    do_op(24'h800000, 24'd4, 24'd0, 1'b1);
    do_op(24'h800000, 24'd4, 24'd0, 1'b0);
    do_op(24'h912345, 24'd30, 24'd0, 1'b1);
`endif

    for (int t = 0; t < 6; t++) begin
      do_op(24'($urandom), 24'($urandom_range(0, 15)), 24'($urandom_range(0, 15)), 1'($urandom));
    end

    // Reset mid-shift aborts with no later done
    @(negedge clk);
    A = 24'hFFFFFF; B = 24'd10; shift_amount = 24'd0; arith_v = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_result", {8'd0, result}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("no_done_after_abort", cnt, 0);

    check("scoreboard_empty", exp_res_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
